execute_stage: RTL and testbench
================================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Clock and reset SHALL be one clock and a synchronous, active-high reset, with ports named CLK and Reset.
REQ-002 CLK  in  1  system clock; all state SHALL change only on the rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 ValA  in  16  operand A, taken from the stage-5 ValAOut register.
REQ-005 ValB  in  16  operand B, taken from the stage-5 ValBOut register.
REQ-006 IR  in  16  instruction, taken from stage-5 IROut; IR[7:0] is the immediate field.
REQ-007 ALUOp  in  3  operation select: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRA, 111 MUL.
REQ-008 ALUSrcB  in  2  B-operand select: 00 ValB, 01 sign-extended immediate, 10 zero-extended immediate, 11 constant 0x0001.
REQ-009 ExStart  in  1  single-cycle request to execute the operation.
REQ-010 ResOut  out  16  registered result, fed back to stage 5.
REQ-011 SignExtOut  out  16  registered sign-extension of IR[7:0], fed to stage 5.
REQ-012 ZeroExtOut  out  16  registered zero-extension of IR[7:0], fed to stage 5.
REQ-013 Zero  out  1  registered flag: ResOut == 0.
REQ-014 Neg  out  1  registered flag: ResOut[15].
REQ-015 Busy  out  1  high while a MUL is in progress.
REQ-016 Done  out  1  one-cycle pulse when a new ResOut is valid.

Function
REQ-017 An edge with ExStart=1 and Busy=0 SHALL accept the request; ExStart while Busy=1 SHALL be ignored, with no state change.
REQ-018 On acceptance, the block SHALL capture SignExtOut = {8{IR[7]},IR[7:0]} and ZeroExtOut = {8'h00,IR[7:0]}; these hold until the next acceptance.
REQ-019 The B operand SHALL be muxed per ALUSrcB from ValB or from the immediate extensions of the same-cycle IR.
REQ-020 All arithmetic SHALL wrap modulo 2^16; there is no carry or overflow output.
REQ-021 SLL and SRA SHALL shift A by B[3:0] only; SRA SHALL replicate A[15].
REQ-022 Single-cycle ops (000-110): ResOut, Zero, Neg SHALL update at the accepting edge; Done=1 for exactly the following cycle; Busy stays 0.
REQ-023 MUL SHALL use a state machine with states IDLE and MUL.
REQ-024 MUL, at the accepting edge: state IDLE->MUL, operands latched, iteration count=0, Busy=1.
REQ-025 MUL SHALL perform one shift-add iteration per edge, producing the low 16 bits of A*B.
REQ-026 MUL, at the 16th iteration edge (accept edge +16): ResOut, Zero and Neg are written, Done=1 for one cycle, Busy=0, state returns to IDLE.
REQ-027 During a MUL, ResOut, Zero and Neg SHALL hold their previous values until completion.
REQ-028 Back-to-back: ExStart in the cycle where Done=1 and Busy=0 SHALL be accepted; the single-cycle op throughput SHALL be 1 per cycle.
REQ-029 Latched MUL operands SHALL make changes on ValA, ValB, IR or ALUOp during Busy have no effect on the result.

Reset
REQ-030 With Reset=1 at an edge, ResOut, SignExtOut and ZeroExtOut SHALL be 0x0000, Zero=1, Neg=0, Busy=0, Done=0, and the state SHALL be IDLE.
REQ-031 Reset during a MUL SHALL abort it with no Done pulse; ExStart coincident with Reset SHALL be ignored.

Structure
REQ-032 A shared package SHALL hold the ALUOp and ALUSrcB encodings, the FSM state encoding and the data width constant (16).
REQ-033 One sub-module, mul_iter, SHALL implement the 16-iteration shift-add multiplier with start, busy and done, instantiated once.

Verification
REQ-034 Reset with all inputs at 0 -> ResOut=0000, Zero=1, Neg=0, Busy=0, Done=0, SignExtOut=ZeroExtOut=0000.
REQ-035 ADD with ValA=0x7FFF, ValB=0x0001, ALUSrcB=00 -> next cycle ResOut=0x8000, Neg=1, Zero=0, Done=1 for one cycle; SUB with ValA=0x0005, ValB=0x0005 -> ResOut=0x0000, Zero=1.
REQ-036 IR=0x00F0, ALUSrcB=01, ADD, ValA=0x0010 -> SignExtOut=0xFFF0, ZeroExtOut=0x00F0, ResOut=0x0000, Zero=1.
REQ-037 MUL with ValA=0x0123, ValB=0x0045 -> Busy=1 for 16 cycles, ResOut=0x4E6F and Done=1 at accept+16; an ExStart pulsed mid-MUL is ignored and the result is unchanged.
REQ-038 MUL started, then Reset asserted at accept+8 -> Busy=0, no Done, ResOut=0x0000; a following SRA with ValA=0x8000, ValB=0x0004 -> ResOut=0xF800.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// Shared encodings and constants for the execute stage and its multiplier.
package execute_stage_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRA = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC_VALB = 2'b00,
        SRC_SEXT = 2'b01,
        SRC_ZEXT = 2'b10,
        SRC_ONE  = 2'b11
    } src_b_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    function automatic logic [DATA_W-1:0] sign_ext8(input logic [7:0] imm);
        return {{(DATA_W-8){imm[7]}}, imm};
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Operand, control and result bundle between stage 5 and the execute stage.
interface execute_stage_if;
    import execute_stage_pkg::*;

    logic [DATA_W-1:0] ValA;
    logic [DATA_W-1:0] ValB;
    logic [DATA_W-1:0] IR;
    logic [2:0]        ALUOp;
    logic [1:0]        ALUSrcB;
    logic              ExStart;
    logic [DATA_W-1:0] ResOut;
    logic [DATA_W-1:0] SignExtOut;
    logic [DATA_W-1:0] ZeroExtOut;
    logic              Zero;
    logic              Neg;
    logic              Busy;
    logic              Done;

    modport master (
        output ValA, ValB, IR, ALUOp, ALUSrcB, ExStart,
        input  ResOut, SignExtOut, ZeroExtOut, Zero, Neg, Busy, Done
    );

    modport slave (
        input  ValA, ValB, IR, ALUOp, ALUSrcB, ExStart,
        output ResOut, SignExtOut, ZeroExtOut, Zero, Neg, Busy, Done
    );

endinterface

// File: rtl/execute_stage_mul_iter.sv
// Iterative shift-add multiplier: one partial product per clock, low DATA_W bits kept.
module mul_iter
    import execute_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] acc_next;

    assign acc_next = mplier[0] ? acc + mcand : acc;
    // done and product are valid during the cycle whose closing edge is the final iteration
    assign done     = busy && (count == LAST);
    assign product  = acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (count == LAST) busy <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            count  <= '0;
            busy   <= 1'b1;
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU ops plus a 16-cycle iterative MUL, registered results and flags.
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic              CLK,
    input  logic              Reset,
    execute_stage_if.slave    bus
);

    state_e            state;
    alu_op_e           op;
    logic [DATA_W-1:0] sext_imm;
    logic [DATA_W-1:0] zext_imm;
    logic [DATA_W-1:0] b_operand;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] mul_product;
    logic              accept;
    logic              mul_start;
    logic              mul_busy;
    logic              mul_done;

    logic [DATA_W-1:0] res_q;
    logic [DATA_W-1:0] sext_q;
    logic [DATA_W-1:0] zext_q;
    logic              zero_q;
    logic              neg_q;
    logic              done_q;

    assign op        = alu_op_e'(bus.ALUOp);
    assign sext_imm  = sign_ext8(bus.IR[7:0]);
    assign zext_imm  = {8'h00, bus.IR[7:0]};
    assign accept    = bus.ExStart && (state == S_IDLE);
    assign mul_start = accept && (op == OP_MUL) && !Reset;

    always_comb begin
        b_operand = bus.ValB;
        case (src_b_e'(bus.ALUSrcB))
            SRC_VALB: b_operand = bus.ValB;
            SRC_SEXT: b_operand = sext_imm;
            SRC_ZEXT: b_operand = zext_imm;
            SRC_ONE:  b_operand = DATA_W'(1);
            default:  b_operand = bus.ValB;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = bus.ValA + b_operand;
            OP_SUB:  alu_res = bus.ValA - b_operand;
            OP_AND:  alu_res = bus.ValA & b_operand;
            OP_OR:   alu_res = bus.ValA | b_operand;
            OP_XOR:  alu_res = bus.ValA ^ b_operand;
            OP_SLL:  alu_res = bus.ValA << b_operand[3:0];
            OP_SRA:  alu_res = DATA_W'($signed(bus.ValA) >>> b_operand[3:0]);
            default: alu_res = '0;
        endcase
    end

    mul_iter u_mul (
        .clk     (CLK),
        .rst     (Reset),
        .start   (mul_start),
        .a       (bus.ValA),
        .b       (b_operand),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state  <= S_IDLE;
            res_q  <= '0;
            sext_q <= '0;
            zext_q <= '0;
            zero_q <= 1'b1;
            neg_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        sext_q <= sext_imm;
                        zext_q <= zext_imm;
                        if (op == OP_MUL) begin
                            state <= S_MUL;
                        end else begin
                            res_q  <= alu_res;
                            zero_q <= (alu_res == '0);
                            neg_q  <= alu_res[DATA_W-1];
                            done_q <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    // Results stay frozen until the multiplier's final iteration edge
                    if (mul_done) begin
                        res_q  <= mul_product;
                        zero_q <= (mul_product == '0);
                        neg_q  <= mul_product[DATA_W-1];
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                    end else if (!mul_busy) begin
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ResOut     = res_q;
    assign bus.SignExtOut = sext_q;
    assign bus.ZeroExtOut = zext_q;
    assign bus.Zero       = zero_q;
    assign bus.Neg        = neg_q;
    assign bus.Done       = done_q;
    assign bus.Busy       = (state == S_MUL);

endmodule

// File: tb/tb_execute_stage.sv
// Directed scoreboard bench for execute_stage: results queued at drive time, checked on Done.
module tb_execute_stage;
    import execute_stage_pkg::*;

    logic CLK   = 1'b0;
    logic Reset = 1'b1;

    execute_stage_if bus ();

    execute_stage dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [15:0] res;
        logic [15:0] sext;
        logic [15:0] zext;
        logic        zero;
        logic        neg;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] last_res = 16'h0000;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] modelB(input logic [1:0] src, input logic [15:0] valb,
                                           input logic [15:0] ir);
        case (src)
            2'b00:   return valb;
            2'b01:   return {{8{ir[7]}}, ir[7:0]};
            2'b10:   return {8'h00, ir[7:0]};
            default: return 16'h0001;
        endcase
    endfunction

    function automatic logic [15:0] modelAlu(input logic [2:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
        logic [15:0] r;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a << b[3:0];
            3'd6: begin
                r = a;
                for (int i = 0; i < int'(b[3:0]); i++) r = {r[15], r[15:1]};
            end
            default: r = a * b;
        endcase
        return r;
    endfunction

    // Drives one ExStart cycle starting at a falling edge; returns at the next falling edge
    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [1:0] src,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] ir, input bit expect_done);
        exp_t e;
        bus.ValA    = a;
        bus.ValB    = b;
        bus.IR      = ir;
        bus.ALUOp   = op;
        bus.ALUSrcB = src;
        bus.ExStart = 1'b1;
        if (expect_done) begin
            e.tag  = tag;
            e.res  = modelAlu(op, a, modelB(src, b, ir));
            e.zero = (e.res == 16'h0000);
            e.neg  = e.res[15];
            e.sext = {{8{ir[7]}}, ir[7:0]};
            e.zext = {8'h00, ir[7:0]};
            sb.push_back(e);
        end
        @(negedge CLK);
        bus.ExStart = 1'b0;
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (bus.Done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $error("[TB] FAIL spurious_done observed=Done=1 expected=no pending result");
            end else begin
                e = sb.pop_front();
                checkOutput({e.tag, "_res"},  bus.ResOut,       e.res);
                checkOutput({e.tag, "_zero"}, 16'(bus.Zero),    16'(e.zero));
                checkOutput({e.tag, "_neg"},  16'(bus.Neg),     16'(e.neg));
                checkOutput({e.tag, "_sext"}, bus.SignExtOut,   e.sext);
                checkOutput({e.tag, "_zext"}, bus.ZeroExtOut,   e.zext);
                last_res = e.res;
            end
        end
    end

    initial begin
        int cycles;

        bus.ValA    = 16'h0000;
        bus.ValB    = 16'h0000;
        bus.IR      = 16'h0000;
        bus.ALUOp   = 3'b000;
        bus.ALUSrcB = 2'b00;
        bus.ExStart = 1'b0;
        Reset       = 1'b1;
        repeat (2) @(negedge CLK);
        checkOutput("reset_res",  bus.ResOut,       16'h0000);
        checkOutput("reset_zero", 16'(bus.Zero),    16'h0001);
        checkOutput("reset_neg",  16'(bus.Neg),     16'h0000);
        checkOutput("reset_busy", 16'(bus.Busy),    16'h0000);
        checkOutput("reset_done", 16'(bus.Done),    16'h0000);
        checkOutput("reset_sext", bus.SignExtOut,   16'h0000);
        checkOutput("reset_zext", bus.ZeroExtOut,   16'h0000);
        Reset = 1'b0;

        applyStimulus("add_wrap", 3'd0, 2'b00, 16'h7FFF, 16'h0001, 16'h0000, 1'b1);
        checkOutput("add_done_high", 16'(bus.Done), 16'h0001);
        checkOutput("add_busy_low",  16'(bus.Busy), 16'h0000);
        @(negedge CLK);
        checkOutput("add_done_pulse", 16'(bus.Done), 16'h0000);

        applyStimulus("sub_zero", 3'd1, 2'b00, 16'h0005, 16'h0005, 16'h0000, 1'b1);
        @(negedge CLK);
        applyStimulus("imm_sext", 3'd0, 2'b01, 16'h0010, 16'h1234, 16'h00F0, 1'b1);
        @(negedge CLK);

        // Back-to-back single-cycle ops, one per clock
        applyStimulus("and_b2b",  3'd2, 2'b00, 16'hF0F0, 16'hFF00, 16'h0011, 1'b1);
        applyStimulus("or_b2b",   3'd3, 2'b00, 16'h0F0F, 16'h8000, 16'h0022, 1'b1);
        applyStimulus("xor_b2b",  3'd4, 2'b00, 16'hAAAA, 16'hAAAA, 16'h0033, 1'b1);
        applyStimulus("sll_b2b",  3'd5, 2'b00, 16'h0001, 16'h0013, 16'h0044, 1'b1);
        applyStimulus("zext_b2b", 3'd0, 2'b10, 16'h1000, 16'h5555, 16'h0080, 1'b1);
        applyStimulus("one_b2b",  3'd1, 2'b11, 16'h0000, 16'h7777, 16'h0001, 1'b1);
        @(negedge CLK);
        checkOutput("b2b_drained", 16'(sb.size()), 16'h0000);

        applyStimulus("mul", 3'd7, 2'b00, 16'h0123, 16'h0045, 16'h00AB, 1'b1);
        cycles = 0;
        for (int iter = 0; iter < 40 && bus.Done !== 1'b1; iter++) begin
            if (bus.Busy === 1'b1) cycles++;
            if (cycles == 6 && bus.ExStart === 1'b0 && bus.ValA == 16'h0123) begin
                bus.ExStart = 1'b1;
                bus.ALUOp   = 3'd0;
                bus.ALUSrcB = 2'b01;
                bus.ValA    = 16'hFFFF;
                bus.ValB    = 16'h0002;
                bus.IR      = 16'h0055;
            end else begin
                bus.ExStart = 1'b0;
            end
            if (cycles == 8) checkOutput("mul_res_hold", bus.ResOut, last_res);
            @(negedge CLK);
        end
        bus.ExStart = 1'b0;
        checkOutput("mul_busy_cycles", 16'(cycles),   16'd16);
        checkOutput("mul_done",        16'(bus.Done), 16'h0001);
        checkOutput("mul_busy_clear",  16'(bus.Busy), 16'h0000);
        @(negedge CLK);
        checkOutput("mul_done_pulse", 16'(bus.Done), 16'h0000);

        applyStimulus("mul_abort", 3'd7, 2'b00, 16'h0123, 16'h0045, 16'h0000, 1'b0);
        checkOutput("abort_busy_start", 16'(bus.Busy), 16'h0001);
        repeat (6) @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);
        checkOutput("abort_busy", 16'(bus.Busy), 16'h0000);
        checkOutput("abort_done", 16'(bus.Done), 16'h0000);
        checkOutput("abort_res",  bus.ResOut,    16'h0000);
        checkOutput("abort_zero", 16'(bus.Zero), 16'h0001);

        // ExStart while Reset is still high must not start anything
        bus.ValA    = 16'h0001;
        bus.ValB    = 16'h0001;
        bus.ALUOp   = 3'd0;
        bus.ALUSrcB = 2'b00;
        bus.IR      = 16'h00C3;
        bus.ExStart = 1'b1;
        @(negedge CLK);
        bus.ExStart = 1'b0;
        Reset       = 1'b0;
        checkOutput("rst_start_res",  bus.ResOut,     16'h0000);
        checkOutput("rst_start_sext", bus.SignExtOut, 16'h0000);
        repeat (20) @(negedge CLK);
        checkOutput("abort_quiet_busy", 16'(bus.Busy), 16'h0000);
        checkOutput("abort_quiet_res",  bus.ResOut,    16'h0000);

        applyStimulus("sra", 3'd6, 2'b00, 16'h8000, 16'h0004, 16'h0000, 1'b1);
        @(negedge CLK);
        checkOutput("sb_empty", 16'(sb.size()), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
